pkt_job_dispatcher: RTL and testbench

- Front-end control stage directly upstream of the two packet builders (pb0, pb1) and the packet parser (pp).
- Accepts packet-build jobs through a valid/ready queue and dispatches each job to a free builder by driving that builder's register-port fields and a start pulse.
- When a builder signals completion, the dispatcher starts the parser on that builder's output header address.
- Returns the parser status to the host as a result stream.

---
 rtl/pkt_dispatch_pkg.sv | 50 +++++
 rtl/job_fifo.sv | 61 ++++++
 rtl/pkt_job_dispatcher.sv | 195 +++++++++++++++++++
 tb/tb_pkt_job_dispatcher.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_dispatch_pkg.sv
// Shared types and constants for the packet job dispatcher: the builder job
// record, the parser status word and the FSM state encodings.
package pkt_dispatch_pkg;

  localparam int ADDR_W   = 32;
  localparam int STATUS_W = 11;
  localparam int NUM_PB   = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr_in;
    logic [3:0]        byte_cnt;
    logic [3:0]        pkt_type;
    logic              ecc_en;
    logic              crc_en;
    logic [1:0]        ins_ecc_err;
    logic              ins_crc_err;
    logic [3:0]        ecc_val;
    logic [7:0]        crc_val;
    logic [2:0]        sop_val;
    logic [3:0]        data_sel;
    logic [ADDR_W-1:0] addr_out;
  } pb_job_t;

  typedef struct packed {
    logic       ecc_corr;
    logic       ecc_uncorr;
    logic       crc_err;
    logic [3:0] byte_cnt;
    logic [3:0] pkt_type;
  } pp_status_t;

  typedef logic [1:0] pb_state_t;
  typedef logic [1:0] pp_state_t;

  localparam pb_state_t PB_IDLE  = 2'd0;
  localparam pb_state_t PB_START = 2'd1;
  localparam pb_state_t PB_WAIT  = 2'd2;
  localparam pb_state_t PB_DONE  = 2'd3;

  localparam pp_state_t PP_IDLE  = 2'd0;
  localparam pp_state_t PP_START = 2'd1;
  localparam pp_state_t PP_WAIT  = 2'd2;
  localparam pp_state_t PP_RESP  = 2'd3;

  // Result word handed back to the host: builder index on top of the status.
  function automatic logic [STATUS_W:0] pack_result(input logic src_id, input pp_status_t status);
    return {src_id, status};
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Small synchronous show-ahead FIFO holding pending builder jobs; the head
// entry is visible combinationally so a grant can load it in the same cycle.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign full      = (count_reg == (PTR_W + 1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

endmodule

// File: rtl/pkt_job_dispatcher.sv
// Job dispatcher: queues build jobs, hands them round-robin to two packet
// builders, then runs the parser on each finished packet and returns its status.
module pkt_job_dispatcher
  import pkt_dispatch_pkg::*;
#(
  parameter int JOB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  pb_job_t             job_i,
  output pb_job_t             pb0_cfg_o,
  output logic                pb0_start_o,
  input  logic                pb0_busy_i,
  input  logic                pb0_irq_i,
  output pb_job_t             pb1_cfg_o,
  output logic                pb1_start_o,
  input  logic                pb1_busy_i,
  input  logic                pb1_irq_i,
  input  logic                ignore_ecc_err_i,
  output logic [ADDR_W-1:0]   pp_addr_hdr_o,
  output logic                pp_ignore_ecc_err_o,
  output logic                pp_start_o,
  input  logic                pp_busy_i,
  input  logic                pp_irq_i,
  input  logic [STATUS_W-1:0] pp_status_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [STATUS_W:0]   res_o
);

  localparam int CNT_W = $clog2(JOB_DEPTH) + 1;

  pb_job_t           fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_pop;

  logic [NUM_PB-1:0] busy_vec;
  logic [NUM_PB-1:0] irq_vec;
  logic [NUM_PB-1:0] idle_vec;
  logic [NUM_PB-1:0] done_vec;
  logic [NUM_PB-1:0] start_vec;
  logic [NUM_PB-1:0] eligible_vec;
  logic [NUM_PB-1:0] grant_vec;
  logic [NUM_PB-1:0] release_vec;
  pb_job_t           cfg_arr [NUM_PB];
  logic              rr_reg;

  job_fifo #(
    .DEPTH (JOB_DEPTH),
    .WIDTH ($bits(pb_job_t))
  ) u_job_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (job_valid_i),
    .push_data (job_i),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign job_ready_o = !fifo_full;

  assign busy_vec = {pb1_busy_i, pb0_busy_i};
  assign irq_vec  = {pb1_irq_i, pb0_irq_i};

  for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_pb
    pb_state_t state_reg;
    pb_state_t state_next;
    pb_job_t   cfg_reg;

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        PB_IDLE:  if (grant_vec[gi])   state_next = PB_START;
        PB_START: state_next = PB_WAIT;
        PB_WAIT:  if (irq_vec[gi])     state_next = PB_DONE;
        PB_DONE:  if (release_vec[gi]) state_next = PB_IDLE;
        default:  state_next = PB_IDLE;
      endcase
    end

    // cfg is only reloaded on a grant, so it stays valid through DONE for the parser.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= PB_IDLE;
        cfg_reg   <= '0;
      end else begin
        state_reg <= state_next;
        if (grant_vec[gi]) begin
          cfg_reg <= fifo_head;
        end
      end
    end

    assign idle_vec[gi]  = (state_reg == PB_IDLE);
    assign done_vec[gi]  = (state_reg == PB_DONE);
    assign start_vec[gi] = (state_reg == PB_START);
    assign cfg_arr[gi]   = cfg_reg;
  end

  assign pb0_cfg_o   = cfg_arr[0];
  assign pb1_cfg_o   = cfg_arr[1];
  assign pb0_start_o = start_vec[0];
  assign pb1_start_o = start_vec[1];

  // rr_reg names the builder preferred when both are free; it flips past each grant.
  assign eligible_vec = idle_vec & ~busy_vec & {NUM_PB{!fifo_empty}};

  always_comb begin
    grant_vec = '0;
    if (&eligible_vec) begin
      grant_vec[rr_reg] = 1'b1;
    end else if (eligible_vec[0]) begin
      grant_vec[0] = 1'b1;
    end else if (eligible_vec[1]) begin
      grant_vec[1] = 1'b1;
    end
  end

  assign fifo_pop = (|grant_vec) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_reg <= 1'b0;
    end else if (grant_vec[0]) begin
      rr_reg <= 1'b1;
    end else if (grant_vec[1]) begin
      rr_reg <= 1'b0;
    end
  end

  pp_state_t           pp_state_reg;
  pp_state_t           pp_state_next;
  logic                pp_take;
  logic                pp_pick_src;
  logic                pp_src_reg;
  logic [ADDR_W-1:0]   pp_addr_hdr_reg;
  logic                pp_ignore_reg;
  logic [STATUS_W:0]   res_reg;

  // Fixed priority: pb0 wins whenever both builders are waiting.
  assign pp_take     = (pp_state_reg == PP_IDLE) && (|done_vec) && !pp_busy_i;
  assign pp_pick_src = !done_vec[0];

  always_comb begin
    release_vec = '0;
    if (pp_take) begin
      release_vec[pp_pick_src] = 1'b1;
    end
  end

  always_comb begin
    pp_state_next = pp_state_reg;
    case (pp_state_reg)
      PP_IDLE:  if (pp_take)     pp_state_next = PP_START;
      PP_START: pp_state_next = PP_WAIT;
      PP_WAIT:  if (pp_irq_i)    pp_state_next = PP_RESP;
      PP_RESP:  if (res_ready_i) pp_state_next = PP_IDLE;
      default:  pp_state_next = PP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pp_state_reg    <= PP_IDLE;
      pp_src_reg      <= 1'b0;
      pp_addr_hdr_reg <= '0;
      pp_ignore_reg   <= 1'b0;
      res_reg         <= '0;
    end else begin
      pp_state_reg <= pp_state_next;
      if (pp_take) begin
        pp_addr_hdr_reg <= cfg_arr[pp_pick_src].addr_out;
        pp_src_reg      <= pp_pick_src;
        pp_ignore_reg   <= ignore_ecc_err_i;
      end
      if ((pp_state_reg == PP_WAIT) && pp_irq_i) begin
        res_reg <= pack_result(pp_src_reg, pp_status_t'(pp_status_i));
      end
    end
  end

  assign pp_addr_hdr_o       = pp_addr_hdr_reg;
  assign pp_ignore_ecc_err_o = pp_ignore_reg;
  assign pp_start_o          = (pp_state_reg == PP_START);
  assign res_valid_o         = (pp_state_reg == PP_RESP);
  assign res_o               = res_reg;

endmodule

// File: tb/tb_pkt_job_dispatcher.sv
// Directed scoreboard bench for pkt_job_dispatcher: stimulus queues expected
// builder starts, parser starts and results; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_pkt_job_dispatcher;
  import pkt_dispatch_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          job_valid_i = 1'b0;
  logic          job_ready_o;
  pb_job_t       job_i = '0;
  pb_job_t       pb0_cfg_o, pb1_cfg_o;
  logic          pb0_start_o, pb1_start_o;
  logic          pb0_busy_i = 1'b0, pb1_busy_i = 1'b0;
  logic          pb0_irq_i = 1'b0, pb1_irq_i = 1'b0;
  logic          ignore_ecc_err_i = 1'b0;
  logic [31:0]   pp_addr_hdr_o;
  logic          pp_ignore_ecc_err_o, pp_start_o;
  logic          pp_busy_i = 1'b0, pp_irq_i = 1'b0;
  logic [10:0]   pp_status_i = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b1;
  logic [11:0]   res_o;

  always #5 clk = ~clk;

  pkt_job_dispatcher #(.JOB_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_i(job_i),
    .pb0_cfg_o(pb0_cfg_o), .pb0_start_o(pb0_start_o), .pb0_busy_i(pb0_busy_i), .pb0_irq_i(pb0_irq_i),
    .pb1_cfg_o(pb1_cfg_o), .pb1_start_o(pb1_start_o), .pb1_busy_i(pb1_busy_i), .pb1_irq_i(pb1_irq_i),
    .ignore_ecc_err_i(ignore_ecc_err_i),
    .pp_addr_hdr_o(pp_addr_hdr_o), .pp_ignore_ecc_err_o(pp_ignore_ecc_err_o), .pp_start_o(pp_start_o),
    .pp_busy_i(pp_busy_i), .pp_irq_i(pp_irq_i), .pp_status_i(pp_status_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o)
  );

  typedef struct { pb_job_t job; int cyc; } start_exp_t;
  typedef struct { logic [31:0] addr; logic ign; } pp_exp_t;

  start_exp_t  exp_pb0[$];
  start_exp_t  exp_pb1[$];
  pp_exp_t     exp_pp[$];
  logic [11:0] exp_res[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event with no expectation queued (cyc %0d)", name, cyc);
  endtask

  start_exp_t  m_s;
  pp_exp_t     m_p;
  logic [11:0] m_r;

  // Monitor: every DUT event pops its expectation and compares.
  always @(negedge clk) begin
    if (pb0_start_o) begin
      if (exp_pb0.size() == 0) unexpected("pb0_start");
      else begin
        m_s = exp_pb0.pop_front();
        check("pb0_cfg", pb0_cfg_o, m_s.job);
        if (m_s.cyc >= 0) check("pb0_start_cyc", cyc, m_s.cyc);
        $display("pb0 start cyc=%0d addr_in=%h addr_out=%h", cyc, pb0_cfg_o.addr_in, pb0_cfg_o.addr_out);
      end
    end
    if (pb1_start_o) begin
      if (exp_pb1.size() == 0) unexpected("pb1_start");
      else begin
        m_s = exp_pb1.pop_front();
        check("pb1_cfg", pb1_cfg_o, m_s.job);
        if (m_s.cyc >= 0) check("pb1_start_cyc", cyc, m_s.cyc);
        $display("pb1 start cyc=%0d addr_in=%h addr_out=%h", cyc, pb1_cfg_o.addr_in, pb1_cfg_o.addr_out);
      end
    end
    if (pp_start_o) begin
      if (exp_pp.size() == 0) unexpected("pp_start");
      else begin
        m_p = exp_pp.pop_front();
        check("pp_addr_hdr", pp_addr_hdr_o, m_p.addr);
        check("pp_ignore", pp_ignore_ecc_err_o, m_p.ign);
        $display("pp start cyc=%0d addr_hdr=%h ignore=%0b", cyc, pp_addr_hdr_o, pp_ignore_ecc_err_o);
      end
    end
    if (res_valid_o && res_ready_i) begin
      if (exp_res.size() == 0) unexpected("result");
      else begin
        m_r = exp_res.pop_front();
        check("res", res_o, m_r);
        $display("result cyc=%0d src=%0d status=%h", cyc, res_o[11], res_o[10:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    job_valid_i = 1'b0; pb0_irq_i = 1'b0; pb1_irq_i = 1'b0; pp_irq_i = 1'b0;
    pb0_busy_i = 1'b0; pb1_busy_i = 1'b0; res_ready_i = 1'b1;
    reset = 1'b1;
    wait_ticks(2);
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pb0_start"}, pb0_start_o, 1'b0);
    check({tag, "_pb1_start"}, pb1_start_o, 1'b0);
    check({tag, "_pp_start"}, pp_start_o, 1'b0);
    check({tag, "_res_valid"}, res_valid_o, 1'b0);
    check({tag, "_job_ready"}, job_ready_o, 1'b1);
    check({tag, "_pp_addr"}, pp_addr_hdr_o, 32'h0);
    check({tag, "_pb0_cfg"}, pb0_cfg_o, 96'h0);
    check({tag, "_res"}, res_o, 12'h0);
  endtask

  // Holds valid until the FIFO accepts; pcyc is the edge count at the accepting edge.
  task automatic push_job(input pb_job_t j, output int pcyc);
    bit ok;
    ok = 1'b0;
    job_i = j;
    job_valid_i = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (job_ready_o) ok = 1'b1;
      tick();
    end
    job_valid_i = 1'b0;
    pcyc = cyc;
    if (!ok) unexpected("push_timeout");
  endtask

  task automatic pulse_pb_irq(input logic b0, input logic b1);
    pb0_irq_i = b0; pb1_irq_i = b1;
    tick();
    pb0_irq_i = 1'b0; pb1_irq_i = 1'b0;
  endtask

  task automatic pulse_pp_irq(input logic [10:0] st);
    pp_status_i = st; pp_irq_i = 1'b1;
    tick();
    pp_irq_i = 1'b0;
  endtask

  task automatic pp_finish(input logic [10:0] st);
    wait_ticks(3);
    pulse_pp_irq(st);
    wait_ticks(2);
  endtask

  function automatic pb_job_t mk_job(input logic [31:0] ain, input logic [31:0] aout,
                                     input logic [3:0] bc, input logic [3:0] pt);
    pb_job_t j;
    j = '0;
    j.addr_in = ain; j.addr_out = aout; j.byte_cnt = bc; j.pkt_type = pt;
    j.crc_en = 1'b1; j.crc_val = ain[7:0] ^ 8'h5a; j.sop_val = 3'd5;
    j.data_sel = pt ^ 4'hf; j.ecc_val = bc;
    return j;
  endfunction

  function automatic start_exp_t se(input pb_job_t j, input int c);
    start_exp_t e;
    e.job = j; e.cyc = c;
    return e;
  endfunction

  function automatic pp_exp_t pe(input logic [31:0] a, input logic ign);
    pp_exp_t e;
    e.addr = a; e.ign = ign;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pb_job_t ja, j1, j2, j3, j4, j5, k1, k2, k3, k4, k5, jb, jc, j7;
    int p, p2;

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // Single job: latency, cfg, parser address, held result
    ignore_ecc_err_i = 1'b1;
    ja = mk_job(32'h100, 32'h200, 4'd5, 4'd1);
    push_job(ja, p);
    exp_pb0.push_back(se(ja, p + 1));
    exp_pp.push_back(pe(32'h200, 1'b1));
    exp_res.push_back(12'h151);
    wait_ticks(3);
    pulse_pb_irq(1'b1, 1'b0);
    wait_ticks(3);
    res_ready_i = 1'b0;
    pulse_pp_irq(11'h151);
    for (int i = 0; i < 3; i++) begin
      check("t1_res_valid_hold", res_valid_o, 1'b1);
      check("t1_res_hold", res_o, 12'h151);
      tick();
    end
    res_ready_i = 1'b1;
    tick();
    check("t1_res_valid_drop", res_valid_o, 1'b0);
    ignore_ecc_err_i = 1'b0;

    // Two back-to-back jobs, pb1 finishes first
    do_reset();
    j1 = mk_job(32'h1000, 32'h2000, 4'd3, 4'd2);
    j2 = mk_job(32'h1100, 32'h2100, 4'd7, 4'd4);
    push_job(j1, p);
    exp_pb0.push_back(se(j1, p + 1));
    push_job(j2, p2);
    exp_pb1.push_back(se(j2, p + 2));
    exp_pp.push_back(pe(32'h2100, 1'b0));
    exp_pp.push_back(pe(32'h2000, 1'b0));
    exp_res.push_back({1'b1, 11'h274});
    exp_res.push_back({1'b0, 11'h432});
    wait_ticks(3);
    pulse_pb_irq(1'b0, 1'b1);
    wait_ticks(1);
    pulse_pb_irq(1'b1, 1'b0);
    pp_finish(11'h274);
    pp_finish(11'h432);

    // Simultaneous builder irqs; pb0 refilled while the parser works
    do_reset();
    j3 = mk_job(32'h3000, 32'h4000, 4'd1, 4'd3);
    j4 = mk_job(32'h3100, 32'h4100, 4'd2, 4'd5);
    j5 = mk_job(32'h3200, 32'h4200, 4'd9, 4'd6);
    push_job(j3, p);
    exp_pb0.push_back(se(j3, p + 1));
    push_job(j4, p);
    exp_pb1.push_back(se(j4, p + 1));
    exp_pp.push_back(pe(32'h4000, 1'b0));
    exp_pp.push_back(pe(32'h4100, 1'b0));
    exp_res.push_back({1'b0, 11'h613});
    exp_res.push_back({1'b1, 11'h025});
    wait_ticks(3);
    pulse_pb_irq(1'b1, 1'b1);
    push_job(j5, p);
    exp_pb0.push_back(se(j5, p + 1));
    pp_finish(11'h613);
    pp_finish(11'h025);

    // FIFO fill with both builders busy
    do_reset();
    pb0_busy_i = 1'b1; pb1_busy_i = 1'b1;
    k1 = mk_job(32'h5000, 32'h6000, 4'd1, 4'd1);
    k2 = mk_job(32'h5100, 32'h6100, 4'd2, 4'd2);
    k3 = mk_job(32'h5200, 32'h6200, 4'd3, 4'd3);
    k4 = mk_job(32'h5300, 32'h6300, 4'd4, 4'd4);
    k5 = mk_job(32'h5400, 32'h6400, 4'd5, 4'd5);
    push_job(k1, p);
    push_job(k2, p);
    push_job(k3, p);
    check("fill_ready_after_3", job_ready_o, 1'b1);
    push_job(k4, p);
    check("fill_ready_after_4", job_ready_o, 1'b0);
    job_i = k5; job_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fill_ready_held_low", job_ready_o, 1'b0);
    end
    exp_pb0.push_back(se(k1, cyc + 1));
    pb0_busy_i = 1'b0;
    tick();
    check("fill_ready_after_grant", job_ready_o, 1'b1);
    tick();
    job_valid_i = 1'b0;
    check("fill_ready_after_5th", job_ready_o, 1'b0);
    exp_pb1.push_back(se(k2, cyc + 1));
    pb1_busy_i = 1'b0;
    tick();
    check("fill_ready_after_2nd_grant", job_ready_o, 1'b1);
    wait_ticks(3);

    // Result stall: second finished builder must wait
    do_reset();
    jb = mk_job(32'h7000, 32'h8000, 4'd6, 4'd7);
    jc = mk_job(32'h7100, 32'h8100, 4'd8, 4'd9);
    push_job(jb, p);
    exp_pb0.push_back(se(jb, p + 1));
    push_job(jc, p);
    exp_pb1.push_back(se(jc, p + 1));
    exp_pp.push_back(pe(32'h8000, 1'b0));
    exp_pp.push_back(pe(32'h8100, 1'b0));
    exp_res.push_back({1'b0, 11'h467});
    exp_res.push_back({1'b1, 11'h089});
    wait_ticks(3);
    pulse_pb_irq(1'b1, 1'b0);
    pulse_pb_irq(1'b0, 1'b1);
    res_ready_i = 1'b0;
    wait_ticks(2);
    pulse_pp_irq(11'h467);
    for (int i = 0; i < 10; i++) begin
      check("stall_res_valid", res_valid_o, 1'b1);
      check("stall_res", res_o, {1'b0, 11'h467});
      check("stall_no_pp_start", pp_start_o, 1'b0);
      tick();
    end
    res_ready_i = 1'b1;
    tick();
    check("stall_res_valid_drop", res_valid_o, 1'b0);
    pp_finish(11'h089);

    // Reset while the parser waits; a late irq must not produce a result
    do_reset();
    j7 = mk_job(32'h9000, 32'ha000, 4'd4, 4'd8);
    push_job(j7, p);
    exp_pb0.push_back(se(j7, p + 1));
    exp_pp.push_back(pe(32'ha000, 1'b0));
    wait_ticks(3);
    pulse_pb_irq(1'b1, 1'b0);
    wait_ticks(3);
    reset = 1'b1;
    tick();
    check_idle_outputs("midreset");
    reset = 1'b0;
    pulse_pp_irq(11'h7ff);
    for (int i = 0; i < 4; i++) begin
      check("late_irq_no_result", res_valid_o, 1'b0);
      tick();
    end

    check("left_pb0", exp_pb0.size(), 0);
    check("left_pb1", exp_pb1.size(), 0);
    check("left_pp", exp_pp.size(), 0);
    check("left_res", exp_res.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
